hazard_sb: RTL and testbench

- Parametrised successor to the pipeline hazard/exception unit of the 5-stage MIPS core.
- Replaces the fixed load-use and branch compare checks with a per-register result-latency scoreboard.
- Owns the divider-busy FSM.
- Latches exception redirects that arrive while the pipeline is frozen by memory stalls, so a redirect is never lost.
- Sits between the datapath stage registers and the PC/flush logic.

---
 rtl/hazard_sb.sv | 120 ++++++++++++
 tb/tb_hazard_sb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - result-latency scoreboard, divider-busy FSM and exception redirect latch
module hazard_sb #(
    parameter int          NREG      = 32,
    parameter int          AW        = 5,
    parameter int          LW        = 2,
    parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE = 32'h0000000e
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_stall,
    input  logic          d_stall,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic          use_rsD,
    input  logic          use_rtD,
    input  logic          validD,
    input  logic          regwriteD,
    input  logic [AW-1:0] writeregD,
    input  logic [LW-1:0] latD,
    input  logic          div_start,
    input  logic          div_done,
    input  logic [31:0]   except_typeM,
    input  logic [31:0]   cp0_epcM,
    output logic          stallF,
    output logic          stallD,
    output logic          stallE,
    output logic          stallM,
    output logic          stallW,
    output logic          flushF,
    output logic          flushD,
    output logic          flushE,
    output logic          flushM,
    output logic          flushW,
    output logic          div_busy,
    output logic          redirect_valid,
    output logic [31:0]   redirect_pc,
    output logic          longest_stall
);

    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;
    typedef enum logic {EXC_IDLE, EXC_PEND} exc_state_t;

    localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};

    logic [NREG-1:0][LW-1:0] cnt_q, cnt_d;
    div_state_t              div_q;
    exc_state_t              exc_q;
    logic [31:0]             pc_q;

    logic        mem_stall, div_stall, gstall;
    logic        src_haz, issue, exc_now;
    logic [31:0] tgt;

    assign mem_stall = i_stall | d_stall;
    assign div_busy  = (div_q == DIV_BUSY);
    assign div_stall = div_busy & ~div_done;
    assign gstall    = mem_stall | div_stall;

    assign src_haz = (use_rsD & (rsD != '0) & (cnt_q[rsD] != '0)) |
                     (use_rtD & (rtD != '0) & (cnt_q[rtD] != '0));

    assign exc_now        = (except_typeM != '0);
    assign tgt            = (except_typeM == ERET_CODE) ? cp0_epcM : EXC_VEC;
    assign redirect_valid = (((exc_q == EXC_IDLE) & exc_now) | (exc_q == EXC_PEND)) & ~mem_stall;
    assign redirect_pc    = (exc_q == EXC_PEND) ? pc_q : tgt;

    assign issue = validD & ~src_haz & ~gstall & ~redirect_valid;

    // A redirect flushes the whole pipe, so it must also release every hold.
    assign stallF = (gstall | src_haz) & ~redirect_valid;
    assign stallD = stallF;
    assign stallE = gstall & ~redirect_valid;
    assign stallM = stallE;
    assign stallW = stallE;
    assign flushF = redirect_valid;
    assign flushD = redirect_valid;
    assign flushE = (src_haz & ~gstall) | redirect_valid;
    assign flushM = redirect_valid;
    assign flushW = redirect_valid;
    assign longest_stall = stallF | stallD | stallE | stallM | stallW;

    always_comb begin
        cnt_d = cnt_q;
        if (!gstall) begin
            for (int i = 0; i < NREG; i++) begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
        if (issue && regwriteD && (writeregD != '0)) cnt_d[writeregD] = latD;
        if (redirect_valid) cnt_d = '0;
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= DIV_IDLE;
            exc_q <= EXC_IDLE;
            pc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (div_q)
                DIV_IDLE: if (div_start && !redirect_valid) div_q <= DIV_BUSY;
                DIV_BUSY: if (div_done || redirect_valid) div_q <= DIV_IDLE;
                default:  div_q <= DIV_IDLE;
            endcase
            // The first exception seen under a memory stall wins until the stall lifts.
            case (exc_q)
                EXC_IDLE: if (exc_now && mem_stall) begin
                    pc_q  <= tgt;
                    exc_q <= EXC_PEND;
                end
                EXC_PEND: if (!mem_stall) exc_q <= EXC_IDLE;
                default:  exc_q <= EXC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_sb.sv
// tb/tb_hazard_sb.sv - scoreboard bench: driver queues expected outputs, negedge monitor compares
module tb_hazard_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall, d_stall;
    logic [4:0]  rsD, rtD, writeregD;
    logic        use_rsD, use_rtD, validD, regwriteD;
    logic [1:0]  latD;
    logic        div_start, div_done;
    logic [31:0] except_typeM, cp0_epcM;
    logic        stallF, stallD, stallE, stallM, stallW;
    logic        flushF, flushD, flushE, flushM, flushW;
    logic        div_busy, redirect_valid, longest_stall;
    logic [31:0] redirect_pc;

    hazard_sb dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
        .rsD(rsD), .rtD(rtD), .use_rsD(use_rsD), .use_rtD(use_rtD),
        .validD(validD), .regwriteD(regwriteD), .writeregD(writeregD), .latD(latD),
        .div_start(div_start), .div_done(div_done),
        .except_typeM(except_typeM), .cp0_epcM(cp0_epcM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .div_busy(div_busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .longest_stall(longest_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] ctl;
        logic [31:0] pc;
        int          id;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    localparam logic [31:0] VEC = 32'hBFC00380;

    // ctl = {stallF,stallD,stallE,stallM,stallW,flushF,flushD,flushE,flushM,flushW,div_busy,redirect_valid,longest_stall}
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [12:0] act;
            e   = q.pop_front();
            act = {stallF, stallD, stallE, stallM, stallW, flushF, flushD, flushE, flushM, flushW,
                   div_busy, redirect_valid, longest_stall};
            checks++;
            if ((act !== e.ctl) || (e.ctl[1] && (redirect_pc !== e.pc))) begin
                failures++;
                $display("FAIL step%0d ctl=%b pc=%h required ctl=%b pc=%h",
                         e.id, act, redirect_pc, e.ctl, e.pc);
            end
        end
    end

    task automatic step(input logic fd, input logic emw, input logic fle, input logic fall,
                        input logic busy, input logic rv, input logic [31:0] pc);
        exp_t e;
        e.ctl = {fd, fd, emw, emw, emw, fall, fall, fle | fall, fall, fall, busy, rv, fd | emw};
        e.pc  = pc;
        e.id  = step_id;
        q.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        i_stall = 0; d_stall = 0; rsD = 0; rtD = 0; use_rsD = 0; use_rtD = 0;
        validD = 0; regwriteD = 0; writeregD = 0; latD = 0;
        div_start = 0; div_done = 0; except_typeM = 0; cp0_epcM = 0;
    endtask

    task automatic idle0();
        step(0, 0, 0, 0, 0, 0, VEC);
    endtask

    initial begin
        clr();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        idle0();
        rst = 0;

        // load-use on $8 with latency 1
        validD = 1; regwriteD = 1; writeregD = 8; latD = 1;
        idle0();
        regwriteD = 0; use_rsD = 1; rsD = 8;
        step(1, 0, 1, 0, 0, 0, VEC);
        idle0();
        regwriteD = 1; writeregD = 0; latD = 3; use_rsD = 0;
        idle0();
        regwriteD = 0; use_rsD = 1; rsD = 0; use_rtD = 1; rtD = 0;
        idle0();

        // latency 2 on $9 frozen by three cycles of d_stall
        clr();
        validD = 1; regwriteD = 1; writeregD = 9; latD = 2;
        idle0();
        regwriteD = 0; use_rtD = 1; rtD = 9; d_stall = 1;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, VEC);
        d_stall = 0;
        step(1, 0, 1, 0, 0, 0, VEC);
        step(1, 0, 1, 0, 0, 0, VEC);
        idle0();

        // divider busy window
        clr();
        div_start = 1;
        idle0();
        div_start = 0;
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 1, 0, VEC);
        div_done = 1;
        step(0, 0, 0, 0, 1, 0, VEC);
        div_done = 0;
        idle0();
        div_done = 1;
        idle0();
        div_done = 0;
        idle0();

        // exception latched under d_stall, later code ignored, counters cleared
        clr();
        validD = 1; regwriteD = 1; writeregD = 10; latD = 3;
        idle0();
        clr();
        d_stall = 1; except_typeM = 32'h4;
        step(1, 1, 0, 0, 0, 0, VEC);
        except_typeM = 32'h8;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, VEC);
        d_stall = 0;
        step(0, 0, 0, 1, 0, 1, VEC);
        except_typeM = 0; validD = 1; use_rsD = 1; rsD = 10;
        idle0();

        // ERET redirects to EPC in the same cycle
        clr();
        except_typeM = 32'he; cp0_epcM = 32'h80001234;
        step(0, 0, 0, 1, 0, 1, 32'h80001234);
        clr();
        idle0();

        // exception aborts a busy divider; late div_done ignored
        div_start = 1;
        idle0();
        div_start = 0;
        step(1, 1, 0, 0, 1, 0, VEC);
        except_typeM = 32'h4;
        step(0, 0, 0, 1, 1, 1, VEC);
        except_typeM = 0;
        idle0();
        div_done = 1;
        idle0();
        div_done = 0;
        idle0();

        // reset while divider busy
        div_start = 1;
        idle0();
        div_start = 0;
        rst = 1;
        step(1, 1, 0, 0, 1, 0, VEC);
        rst = 0;
        idle0();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d required completion", checks);
        $fatal(1, "timeout");
    end

endmodule
